// File: rtl/ef_smsdac_pkg.sv
// Shared definitions for the segmented SMS-DAC encoder/decoder blocks.
// Segment levels are unsigned 0..2. Segment differences are signed -1..+1.
// Shaping accumulators are 3-bit signed.
package ef_smsdac_pkg;

   localparam int NSEG       = 7;
   localparam int TOP_WEIGHT = 128;
   localparam int DOUT_W     = 9;

   typedef logic        [1:0] lvl_t;
   typedef logic signed [1:0] diff_t;
   typedef logic signed [2:0] sacc_t;

   // Number of active unit elements in a 3-level segment code.
   function automatic lvl_t seg_level(input logic [1:0] y);
      return lvl_t'({1'b0, y[0]} + {1'b0, y[1]});
   endfunction

   // Switching direction of a segment code: +1 for 2'b10, -1 for 2'b01.
   function automatic diff_t seg_diff(input logic [1:0] y);
      return diff_t'($signed({1'b0, y[1]}) - $signed({1'b0, y[0]}));
   endfunction

endpackage

// File: rtl/ef_smsdac_msd_seg.sv
// One segment of the mismatch-shaping decoder.
// Holds the stage-1 level register and, when EF_SMSDAC_MSD_SHAPE_CHK_EN
// is defined, the running direction sum S_k and the sticky viol bit.
module ef_smsdac_msd_seg
   import ef_smsdac_pkg::*;
(
   input  logic       clk,
   input  logic       rst_b,
   input  logic       vld,
   input  logic       clr_err,
   input  logic [1:0] y,
   output logic [1:0] lvl,
   output logic       viol
);

   // Stage-1 level capture; holds through bubbles.
   always_ff @(posedge clk) begin
      if (!rst_b)   lvl <= '0;
      else if (vld) lvl <= seg_level(y);
   end

`ifdef EF_SMSDAC_MSD_SHAPE_CHK_EN
   sacc_t s;
   sacc_t s_sum;
   logic  s_ovf;

   // Candidate sum; a first-order shaped sequence never leaves -1..+1.
   always_comb begin
      s_sum = s + sacc_t'(seg_diff(y));
      s_ovf = (s_sum > 3'sd1) || (s_sum < -3'sd1);
   end

   // Accumulator clamps on overflow; clr_err clears only the flag, not S_k.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         s    <= '0;
         viol <= 1'b0;
      end else begin
         if (vld) begin
            if (s_sum > 3'sd1)       s <= 3'sd1;
            else if (s_sum < -3'sd1) s <= -3'sd1;
            else                     s <= s_sum;
         end
         if (clr_err)            viol <= 1'b0;
         else if (vld && s_ovf)  viol <= 1'b1;
      end
   end
`else
   logic unused_shape;
   assign unused_shape = clr_err;
   assign viol         = 1'b0;
`endif

endmodule

// File: rtl/ef_smsdac_msd.sv
// Mismatch-shaping decoder/monitor for the segmented SMS-DAC.
// Reconstructs the DAC value from y6..y0/y_c and compares it against x_ref.
// The two-stage pipeline gives a latency of 2 cycles.
// The shaping monitor is present only when EF_SMSDAC_MSD_SHAPE_CHK_EN is defined.
module ef_smsdac_msd
   import ef_smsdac_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 in_valid,
   input  logic [1:0]           y6,
   input  logic [1:0]           y5,
   input  logic [1:0]           y4,
   input  logic [1:0]           y3,
   input  logic [1:0]           y2,
   input  logic [1:0]           y1,
   input  logic [1:0]           y0,
   input  logic                 y_c,
   input  logic [8:0]           x_ref,
   input  logic                 clr_err,
   output logic [8:0]           dout,
   output logic                 dout_valid,
   output logic                 mismatch,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [6:0]           viol
);

   logic [NSEG-1:0][1:0] y_all;
   logic [NSEG-1:0][1:0] lvl_q;
   logic [NSEG-1:0]      viol_seg;
   logic [2:1]           vld_pipe;
   logic                 yc_q;
   logic [DOUT_W-1:0]    xref_q;
   logic [DOUT_W-1:0]    sum;

   assign y_all      = {y6, y5, y4, y3, y2, y1, y0};
   assign viol       = viol_seg;
   assign dout_valid = vld_pipe[2];

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      ef_smsdac_msd_seg u_seg (
         .clk     (clk),
         .rst_b   (rst_b),
         .vld     (in_valid),
         .clr_err (clr_err),
         .y       (y_all[k]),
         .lvl     (lvl_q[k]),
         .viol    (viol_seg[k])
      );
   end

   // Valid shift; bubbles propagate as zeros, reset drops in-flight samples.
   always_ff @(posedge clk) begin
      if (!rst_b) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[1], in_valid};
   end

   // Stage-1 capture of carry and reference, only on accepted samples.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         yc_q   <= 1'b0;
         xref_q <= '0;
      end else if (in_valid) begin
         yc_q   <= y_c;
         xref_q <= x_ref;
      end
   end

   // Weighted sum of stage-1 levels; max 382 so DOUT_W never overflows.
   always_comb begin
      sum = yc_q ? DOUT_W'(TOP_WEIGHT) : '0;
      for (int k = 0; k < NSEG; k++)
         sum = sum + (DOUT_W'(lvl_q[k]) << k);
   end

   // Stage 2: dout holds across bubbles, mismatch is zero when not valid.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         dout     <= '0;
         mismatch <= 1'b0;
      end else begin
         mismatch <= vld_pipe[1] && (sum != xref_q);
         if (vld_pipe[1]) dout <= sum;
      end
   end

   // Error bookkeeping one cycle behind mismatch; clr_err has priority.
   always_ff @(posedge clk) begin
      if (!rst_b || clr_err) begin
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else if (mismatch && dout_valid) begin
         err_sticky <= 1'b1;
         if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ef_smsdac_msd.sv
// Scoreboard bench for ef_smsdac_msd: stimulus pushes hand-computed expected
// dout/mismatch; a negedge monitor pops and compares on every dout_valid.
module tb_ef_smsdac_msd;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] y6 = '0, y5 = '0, y4 = '0, y3 = '0, y2 = '0, y1 = '0, y0 = '0;
   logic       y_c = 1'b0;
   logic [8:0] x_ref = '0;
   logic       clr_err = 1'b0;
   logic [8:0] dout;
   logic       dout_valid;
   logic       mismatch;
   logic       err_sticky;
   logic [7:0] err_cnt;
   logic [6:0] viol;

`ifdef EF_SMSDAC_MSD_SHAPE_CHK_EN
   localparam logic [6:0] VIOL3 = 7'h08;
`else
   localparam logic [6:0] VIOL3 = 7'h00;
`endif

   typedef struct {
      logic [8:0] d;
      logic       mm;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;
   int   vcnt;
   logic yc;

   ef_smsdac_msd #(.ERR_CNT_W(8)) dut (
      .clk(clk), .rst_b(rst_b), .in_valid(in_valid),
      .y6(y6), .y5(y5), .y4(y4), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
      .y_c(y_c), .x_ref(x_ref), .clr_err(clr_err),
      .dout(dout), .dout_valid(dout_valid), .mismatch(mismatch),
      .err_sticky(err_sticky), .err_cnt(err_cnt), .viol(viol)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0][1:0] yv, input logic c, input logic [8:0] xr, input logic v);
      y0 = yv[0]; y1 = yv[1]; y2 = yv[2]; y3 = yv[3];
      y4 = yv[4]; y5 = yv[5]; y6 = yv[6];
      y_c = c; x_ref = xr; in_valid = v;
   endtask

   task automatic send(input logic [6:0][1:0] yv, input logic c, input logic [8:0] xr, input logic [8:0] dexp);
      @(posedge clk); #1;
      drive(yv, c, xr, 1'b1);
      q.push_back('{d: dexp, mm: (dexp != xr)});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
      idle(1);
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic clear_errs();
      @(posedge clk); #1;
      in_valid = 1'b0; clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
   endtask

   // Monitor: every dout_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (dout_valid === 1'b1) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_valid: got dout=%0d want no output", dout);
            end else begin
               e = q.pop_front();
               chk("dout", 32'(dout), 32'(e.d));
               chk("mismatch", 32'(mismatch), 32'(e.mm));
            end
         end else begin
            chk("mismatch_idle", 32'(mismatch), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with random inputs.
      drive(14'($urandom), 1'($urandom), 9'($urandom), 1'($urandom));
      repeat (2) begin
         @(posedge clk); #1;
         drive(14'($urandom), 1'($urandom), 9'($urandom), 1'($urandom));
         clr_err = 1'($urandom);
      end
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_mm", 32'(mismatch), 32'd0);
      chk("rst_sticky", 32'(err_sticky), 32'd0);
      chk("rst_cnt", 32'(err_cnt), 32'd0);
      chk("rst_viol", 32'(viol), 32'd0);
      rst_b = 1'b1; in_valid = 1'b0; clr_err = 1'b0;
      mon_en = 1'b1;
      idle(1); chk("post_rst_valid0", 32'(dout_valid), 32'd0);
      idle(1); chk("post_rst_valid1", 32'(dout_valid), 32'd0);

      // Reconstruction and latency: y0=11, y_c=1 -> 130.
      send(14'h0003, 1'b1, 9'd130, 9'd130);
      idle(1); chk("lat1_valid", 32'(dout_valid), 32'd0);
      idle(1); chk("lat2_valid", 32'(dout_valid), 32'd1);
      chk("lat2_dout", 32'(dout), 32'd130);
      chk("lat2_mm", 32'(mismatch), 32'd0);

      // Mismatch, then clear.
      send(14'h0003, 1'b1, 9'd131, 9'd130);
      idle(3);
      chk("mm_sticky", 32'(err_sticky), 32'd1);
      chk("mm_cnt", 32'(err_cnt), 32'd1);
      clear_errs();
      chk("clr_cnt", 32'(err_cnt), 32'd0);
      chk("clr_sticky", 32'(err_sticky), 32'd0);

      // Directed reconstruction table, all shaping-legal.
      send(14'h3FFF, 1'b1, 9'd382, 9'd382);
      send(14'h330C, 1'b0, 9'd164, 9'd164);
      send(14'h0021, 1'b1, 9'd133, 9'd133);
      send(14'h0012, 1'b0, 9'd5,   9'd5);
      idle(1);
      send(14'h0000, 1'b0, 9'd0,   9'd0);
      drain();
      chk("tbl_viol", 32'(viol), 32'd0);
      chk("tbl_cnt", 32'(err_cnt), 32'd0);
      chk("hold_dout", 32'(dout), 32'd0);

      // Shaping violation: y3=10 twice in a row.
      send(14'h0080, 1'b0, 9'd8, 9'd8);
      send(14'h0080, 1'b0, 9'd8, 9'd8);
      chk("viol_first", 32'(viol), 32'd0);
      idle(1);
      chk("viol_second", 32'(viol), 32'(VIOL3));
      drain();
      clear_errs();
      chk("viol_clr", 32'(viol), 32'd0);

      // Legal alternating y5 with a bubble every 7th cycle.
      vcnt = 0;
      for (int cyc = 1; vcnt < 100; cyc++) begin
         if (cyc % 7 == 0) idle(1);
         else begin
            yc = (vcnt % 3 == 0);
            send((vcnt % 2 == 0) ? 14'h0800 : 14'h0400, yc,
                 yc ? 9'd160 : 9'd32, yc ? 9'd160 : 9'd32);
            vcnt++;
         end
      end
      drain();
      chk("legal_viol", 32'(viol), 32'd0);
      chk("legal_cnt", 32'(err_cnt), 32'd0);
      chk("legal_sticky", 32'(err_sticky), 32'd0);

      // Saturation, then reset mid-stream.
      for (int i = 0; i < 303; i++) begin
         send(14'h0000, 1'b0, 9'd1, 9'd0);
         if (i == 299) begin
            chk("sat_cnt", 32'(err_cnt), 32'd255);
            chk("sat_sticky", 32'(err_sticky), 32'd1);
         end
      end
      @(posedge clk); #1;
      rst_b = 1'b0; in_valid = 1'b0;
      @(negedge clk); #1;
      q.delete();
      @(posedge clk); #1;
      chk("mrst_cnt", 32'(err_cnt), 32'd0);
      chk("mrst_valid", 32'(dout_valid), 32'd0);
      chk("mrst_dout", 32'(dout), 32'd0);
      chk("mrst_sticky", 32'(err_sticky), 32'd0);
      rst_b = 1'b1;
      idle(4);
      chk("mrst_flush", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
